// File: rtl/reg_file_8x24.sv
// 8-entry register file with a write port, two combinational read ports,
// write-to-read bypass and per-register busy (pending-write) scoreboard bits.
// R0 is hardwired to zero and can never be marked busy.
module reg_file_8x24 #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 8
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             RegWrite,
   input  logic [2:0]       WriteAddr,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [2:0]       ReadAddr1,
   input  logic [2:0]       ReadAddr2,
   input  logic             BusySet,
   input  logic [2:0]       BusyAddr,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2,
   output logic             Stall
);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;

   logic w_wr_en;
   logic w_byp1;
   logic w_byp2;
   logic w_clr1;
   logic w_clr2;

   assign w_wr_en = RegWrite && (WriteAddr != 3'd0);

   // Storage and busy bits; reset wins, then write/clear, then busy set (set wins)
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_en) begin
            r_regs[WriteAddr] <= WriteData;
         end
         if (RegWrite) begin
            r_busy[WriteAddr] <= 1'b0;
         end
         if (BusySet && (BusyAddr != 3'd0)) begin
            r_busy[BusyAddr] <= 1'b1;
         end
      end
   end

   // Bypass is suppressed in reset so the ports show stored values only
   assign w_byp1 = Resetn && w_wr_en && (WriteAddr == ReadAddr1);
   assign w_byp2 = Resetn && w_wr_en && (WriteAddr == ReadAddr2);

   // A register being written this cycle is no longer a hazard
   assign w_clr1 = RegWrite && (WriteAddr == ReadAddr1);
   assign w_clr2 = RegWrite && (WriteAddr == ReadAddr2);

   // Combinational read ports with bypass; R0 always reads zero
   always_comb begin
      ReadData1 = r_regs[ReadAddr1];
      ReadData2 = r_regs[ReadAddr2];
      if (w_byp1) begin
         ReadData1 = WriteData;
      end
      if (w_byp2) begin
         ReadData2 = WriteData;
      end
      if (ReadAddr1 == 3'd0) begin
         ReadData1 = '0;
      end
      if (ReadAddr2 == 3'd0) begin
         ReadData2 = '0;
      end
   end

   // Stall when either operand waits on an outstanding write
   always_comb begin
      Stall = (r_busy[ReadAddr1] && !w_clr1) || (r_busy[ReadAddr2] && !w_clr2);
   end

endmodule

// File: tb/tb_reg_file_8x24.sv
// Scoreboard bench for reg_file_8x24: expected port values are pushed when a
// cycle is driven and popped/compared at the falling edge of that cycle.
module tb_reg_file_8x24;

   logic        clk;
   logic        rstn;
   logic        we;
   logic [2:0]  wa;
   logic [23:0] wd;
   logic [2:0]  ra1;
   logic [2:0]  ra2;
   logic        bs;
   logic [2:0]  ba;
   logic [23:0] rd1;
   logic [23:0] rd2;
   logic        stall;

   typedef struct {
      string       tag;
      logic [23:0] rd1;
      logic [23:0] rd2;
      logic        stall;
   } exp_t;

   exp_t        sb_q[$];
   logic [23:0] m_regs [8];
   logic [7:0]  m_busy;
   int          n_tests;
   int          n_fail;

   reg_file_8x24 #(
      .WIDTH(24),
      .DEPTH(8)
   ) u_dut (
      .Clock    (clk),
      .Resetn   (rstn),
      .RegWrite (we),
      .WriteAddr(wa),
      .WriteData(wd),
      .ReadAddr1(ra1),
      .ReadAddr2(ra2),
      .BusySet  (bs),
      .BusyAddr (ba),
      .ReadData1(rd1),
      .ReadData2(rd2),
      .Stall    (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %06h expected %06h", tag, got, exp);
      end
   endtask

   // Drive one cycle, predict outputs, compare at negedge, update model at posedge
   task automatic step(input string tag, input logic i_rstn, input logic i_we,
                       input logic [2:0] i_wa, input logic [23:0] i_wd,
                       input logic [2:0] i_ra1, input logic [2:0] i_ra2,
                       input logic i_bs, input logic [2:0] i_ba);
      exp_t e;
      exp_t g;
      rstn = i_rstn;
      we   = i_we;
      wa   = i_wa;
      wd   = i_wd;
      ra1  = i_ra1;
      ra2  = i_ra2;
      bs   = i_bs;
      ba   = i_ba;
      e.tag = tag;
      e.rd1 = m_regs[i_ra1];
      e.rd2 = m_regs[i_ra2];
      if (i_rstn && i_we && i_wa != 3'd0 && i_wa == i_ra1) e.rd1 = i_wd;
      if (i_rstn && i_we && i_wa != 3'd0 && i_wa == i_ra2) e.rd2 = i_wd;
      if (i_ra1 == 3'd0) e.rd1 = 24'd0;
      if (i_ra2 == 3'd0) e.rd2 = 24'd0;
      e.stall = (m_busy[i_ra1] && !(i_we && i_wa == i_ra1)) ||
                (m_busy[i_ra2] && !(i_we && i_wa == i_ra2));
      sb_q.push_back(e);
      @(negedge clk);
      g = sb_q.pop_front();
      check_val({g.tag, ".rd1"}, rd1, g.rd1);
      check_val({g.tag, ".rd2"}, rd2, g.rd2);
      check_val({g.tag, ".stall"}, {23'd0, stall}, {23'd0, g.stall});
      @(posedge clk);
      if (!i_rstn) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 24'd0;
         m_busy = 8'd0;
      end else begin
         if (i_we && i_wa != 3'd0) m_regs[i_wa] = i_wd;
         if (i_we) m_busy[i_wa] = 1'b0;
         if (i_bs && i_ba != 3'd0) m_busy[i_ba] = 1'b1;
      end
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 24'd0;
      m_busy = 8'd0;
      rstn = 1'b0;
      we   = 1'b0;
      wa   = 3'd0;
      wd   = 24'd0;
      ra1  = 3'd0;
      ra2  = 3'd0;
      bs   = 1'b0;
      ba   = 3'd0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      step("rst", 1'b0, 1'b0, 3'd0, 24'd0, 3'd1, 3'd7, 1'b0, 3'd0);
      step("idle", 1'b1, 1'b0, 3'd0, 24'd0, 3'd3, 3'd5, 1'b0, 3'd0);

      // Write then read R3
      step("wr_r3", 1'b1, 1'b1, 3'd3, 24'hABCDEF, 3'd1, 3'd0, 1'b0, 3'd0);
      step("rd_r3", 1'b1, 1'b0, 3'd0, 24'd0, 3'd3, 3'd0, 1'b0, 3'd0);

      // Same-cycle bypass on port 2
      step("byp_r5", 1'b1, 1'b1, 3'd5, 24'h123456, 3'd3, 3'd5, 1'b0, 3'd0);
      step("rd_r5", 1'b1, 1'b0, 3'd0, 24'd0, 3'd5, 3'd5, 1'b0, 3'd0);

      // R0 is constant zero and never busy
      step("wr_r0", 1'b1, 1'b1, 3'd0, 24'hFFFFFF, 3'd0, 3'd0, 1'b0, 3'd0);
      step("rd_r0", 1'b1, 1'b0, 3'd0, 24'd0, 3'd0, 3'd0, 1'b0, 3'd0);
      step("bs_r0", 1'b1, 1'b0, 3'd0, 24'd0, 3'd0, 3'd0, 1'b1, 3'd0);
      step("st_r0", 1'b1, 1'b0, 3'd0, 24'd0, 3'd0, 3'd0, 1'b0, 3'd0);

      // Busy R2, stall, then clearing write
      step("bs_r2", 1'b1, 1'b0, 3'd0, 24'd0, 3'd0, 3'd0, 1'b1, 3'd2);
      step("st_r2", 1'b1, 1'b0, 3'd0, 24'd0, 3'd2, 3'd0, 1'b0, 3'd0);
      step("clr_r2", 1'b1, 1'b1, 3'd2, 24'h000777, 3'd2, 3'd0, 1'b0, 3'd0);
      step("post_r2", 1'b1, 1'b0, 3'd0, 24'd0, 3'd2, 3'd0, 1'b0, 3'd0);

      // Busy set wins over clear on same address
      step("bs_wr_r4", 1'b1, 1'b1, 3'd4, 24'h444444, 3'd0, 3'd1, 1'b1, 3'd4);
      step("st_r4", 1'b1, 1'b0, 3'd0, 24'd0, 3'd4, 3'd4, 1'b0, 3'd0);
      step("rebs_r4", 1'b1, 1'b0, 3'd0, 24'd0, 3'd0, 3'd4, 1'b1, 3'd4);

      // Fill all registers, busy R6, reset mid-operation
      for (int i = 0; i < 8; i++) begin
         step("fill", 1'b1, 1'b1, 3'(i), 24'h100000 + 24'(i * 24'h011111), 3'(i), 3'(7 - i),
              1'b0, 3'd0);
      end
      step("bs_r6", 1'b1, 1'b0, 3'd0, 24'd0, 3'd6, 3'd1, 1'b1, 3'd6);
      step("mid_rst", 1'b0, 1'b1, 3'd3, 24'h0BAD00, 3'd6, 3'd3, 1'b1, 3'd5);
      for (int i = 0; i < 8; i++) begin
         step("post_rst", 1'b1, 1'b0, 3'd0, 24'd0, 3'(i), 3'(7 - i), 1'b0, 3'd0);
      end
      step("first_wr", 1'b1, 1'b1, 3'd6, 24'h00C0DE, 3'd6, 3'd5, 1'b0, 3'd0);

      // Random traffic with occasional reset
      for (int n = 0; n < 80; n++) begin
         step("rand", ($urandom_range(15) != 0), 1'($urandom), 3'($urandom), 24'($urandom),
              3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_8x24.md
REG_FILE_8X24 -- requirements
Module: reg_file_8x24

Interface
REQ-001 SHALL have parameter WIDTH, default 24, data width of every register and data port.
REQ-002 SHALL have parameter DEPTH, default 8, register count; address width is 3 bits.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port RegWrite  input  1  write enable for write port.
REQ-006 SHALL have port WriteAddr  input  3  destination register index.
REQ-007 SHALL have port WriteData  input  WIDTH  value to write.
REQ-008 SHALL have port ReadAddr1  input  3  read port 1 index (operand A select).
REQ-009 SHALL have port ReadAddr2  input  3  read port 2 index (operand B select).
REQ-010 SHALL have port BusySet  input  1  mark BusyAddr as pending-write (issue of multi-cycle op).
REQ-011 SHALL have port BusyAddr  input  3  register index to mark busy.
REQ-012 SHALL have port ReadData1  output  WIDTH  read port 1 data.
REQ-013 SHALL have port ReadData2  output  WIDTH  read port 2 data.
REQ-014 SHALL have port Stall  output  1  high when either read port addresses a busy register.

Function
REQ-015 SHALL hold DEPTH x WIDTH storage registers R0..R7 plus 8 busy bits.
REQ-016 SHALL write WriteData into R[WriteAddr] on rising Clock when RegWrite=1 and Resetn=1; no other register changes.
REQ-017 SHALL treat R0 as constant zero: writes to R0 ignored, reads of R0 return 0, busy bit 0 never sets.
REQ-018 SHALL provide combinational reads (zero-cycle latency): ReadDataN = R[ReadAddrN], each port an independent 8:1 selection.
REQ-019 SHALL bypass: when RegWrite=1, WriteAddr=ReadAddrN and WriteAddr!=0, ReadDataN = WriteData in the same cycle.
REQ-020 SHALL, when both read ports select same register, return identical data on both ports.
REQ-021 SHALL set busy[BusyAddr] on rising Clock when BusySet=1 and BusyAddr!=0.
REQ-022 SHALL clear busy[WriteAddr] on rising Clock when RegWrite=1.
REQ-023 SHALL, on simultaneous BusySet and RegWrite to the same nonzero address, leave busy bit set (set wins) while still writing data.
REQ-024 SHALL drive Stall = (busy[ReadAddr1] and not clearing-this-cycle) OR (busy[ReadAddr2] and not clearing-this-cycle), where clearing-this-cycle means RegWrite=1 with WriteAddr equal to that read address.
REQ-025 SHALL leave BusySet to an already-busy register with no effect (bit stays 1).
REQ-026 SHALL keep all state unchanged in cycles with RegWrite=0 and BusySet=0.

Reset
REQ-027 SHALL, on rising Clock with Resetn=0, clear R0..R7 to 0 and all busy bits to 0, ignoring RegWrite and BusySet that cycle.
REQ-028 SHALL, during reset, output ReadData1=ReadData2=stored values (0 after first reset edge) and Stall=0 after first reset edge.
REQ-029 SHALL, on reset asserted mid-operation (busy bits set, writes pending), discard all pending state; first post-reset write behaves as REQ-016.

Verification
REQ-030 SHALL cover: reset, write R3=0xABCDEF, next cycle ReadAddr1=3 -> ReadData1=0xABCDEF, ReadData2 (addr 0)=0.
REQ-031 SHALL cover: RegWrite to R5=0x123456 with ReadAddr2=5 same cycle -> ReadData2=0x123456 combinationally (bypass).
REQ-032 SHALL cover: write R0=0xFFFFFF, then read R0 -> 0x000000; BusySet on R0 -> Stall stays 0.
REQ-033 SHALL cover: BusySet R2, next cycle ReadAddr1=2 -> Stall=1; RegWrite R2=0x000777 same cycle -> Stall=0, ReadData1=0x000777; following cycle Stall=0.
REQ-034 SHALL cover: BusySet and RegWrite both to R4 same cycle -> R4 updated, busy[4]=1, next read of R4 gives Stall=1.
REQ-035 SHALL cover: load all 8 registers with distinct values, set busy on R6, assert Resetn=0 one cycle -> all reads 0, Stall=0.
